sram_sp_bytemask_ctl: RTL and testbench
=======================================

// Module: sram_sp_bytemask_ctl
// PURPOSE
//  Parametrised single-port byte-masked SRAM with request/response handshake; generalises the fixed
//  128x32 byte-lane macro model to any width/depth. Adds post-reset zero-fill, out-of-range detection
//  and an optional output pipeline stage. Sits between core LSU/fetch ports and on-chip data memory.
// PARAMETERS
//  DATA_W   32   data width in bits; must be a multiple of 8 (byte lanes NB = DATA_W/8)
//  DEPTH    128  number of words; need not be a power of two (AW = $clog2(DEPTH), min 1)
//  CLEAR_EN 1    1: zero-fill all words after reset; 0: skip fill, ready immediately
// PORTS
//  clk        in   1       clock, all logic on rising edge
//  rst        in   1       synchronous reset, active-high
//  req_valid  in   1       request present
//  req_ready  out  1       block accepts request this cycle
//  req_we     in   1       1 write, 0 read
//  req_be     in   NB      per-byte write enable (ignored on reads)
//  req_addr   in   AW      word address
//  req_wdata  in   DATA_W  write data
//  rsp_valid  out  1       one-cycle pulse: read data valid
//  rsp_rdata  out  DATA_W  read data; holds last value between reads
//  rsp_err    out  1       qualifies rsp_valid: address >= DEPTH
//  init_done  out  1       zero-fill complete (or CLEAR_EN=0)
// BEHAVIOUR
//  - Clock clk; reset rst is synchronous and active-high.
//  - Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_done=0; FSM->CLEAR
//    (CLEAR_EN=1) or IDLE (CLEAR_EN=0, init_done=1 and req_ready=1 from first cycle after reset).
//  - FSM CLEAR: clr_ptr 0..DEPTH-1, writes all lanes =0 one word/cycle; req_ready=0; after
//    writing DEPTH-1 -> IDLE, init_done=1 same edge. Fill takes exactly DEPTH cycles.
//  - FSM IDLE: req_ready=1 every cycle (no internal stalls). Handshake = req_valid & req_ready.
//  - Write: lanes i with req_be[i]=1 take req_wdata[8i+:8]; other lanes unchanged; no response.
//    req_be=0 write is a legal no-op.
//  - Read: mem word registered; rsp_valid=1 exactly LAT cycles after handshake, LAT=1 (2 with
//    SRAM_OUTREG_EN). Back-to-back reads give back-to-back pulses; no response backpressure.
//  - rsp_rdata updates only with rsp_valid; otherwise holds. Write-then-read same address on
//    consecutive cycles returns new data (single port, write completes first).
//  - Out-of-range (req_addr >= DEPTH): write dropped, memory untouched; read gives rsp_valid=1,
//    rsp_err=1, rsp_rdata=0 at normal latency. rsp_err=0 with every in-range rsp_valid.
//  - rst mid-fill restarts fill at address 0; rst with reads in flight drops them (no rsp_valid).
//  - Memory array itself not reset except via fill; CLEAR_EN=0 leaves contents undefined (X in sim).
//  - Requests during CLEAR are not accepted (req_ready=0); requester holds them.
// CONFIGURATION
//  SRAM_OUTREG_EN defined: extra register after array read; read latency 2, fully pipelined
//    (one read/cycle), rsp_err/rsp_rdata travel in the same stage; reset clears both stages.
//  SRAM_OUTREG_EN undefined: read latency 1, array output drives rsp_rdata directly.
//  Write behaviour, fill timing and handshake identical in both builds.
// TESTING
//  1 rst 1 cycle, DEPTH=128, CLEAR_EN=1 -> req_ready=0 for 128 cycles, then init_done=1;
//    read every addr -> rsp_rdata=0x00000000, rsp_err=0.
//  2 write 0x11223344 @5 be=4'hF; write 0xAABBCCDD @5 be=4'b0101; read @5 -> 0x11BB33DD
//    after exactly LAT cycles.
//  3 DEPTH=100: write 0xDEADBEEF @100 then read @100 -> rsp_valid=1, rsp_err=1, rsp_rdata=0;
//    read @99 -> rsp_err=0, data unchanged.
//  4 reads @0,@1,@2 on consecutive cycles (LAT=2 build) -> three consecutive rsp_valid pulses
//    in order; rsp_rdata holds last value afterwards with rsp_valid=0.
//  5 assert rst at fill cycle 60 -> fill restarts, init_done rises 128 cycles after rst drop;
//    rst with read in flight -> no rsp_valid, rsp_rdata=0.
//  6 DATA_W=64, DEPTH=16, CLEAR_EN=0 -> req_ready=1 first cycle after rst; write 8 lanes with
//    be=8'h80 data 0xFF.. then read -> byte 7 = 0xFF, bytes 0-6 X/untouched (ignore compare).

Source files
------------

// File: rtl/sram_sp_bytemask_ctl.sv
// Single-port byte-masked SRAM with request/response handshake, post-reset zero-fill and out-of-range flagging.
// Optional build macro SRAM_OUTREG_EN adds an output register stage (read latency 2 instead of 1).

module sram_sp_bytemask_ctl #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 128,
    parameter int CLEAR_EN = 1,
    localparam int NB      = DATA_W / 8,
    localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [NB-1:0]     req_be,
    input  logic [AW-1:0]     req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              init_done
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW:0]   DEPTH_W   = (AW + 1)'(DEPTH);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     clr_ptr_q, clr_ptr_d;
    logic              fill_we;

    logic              hs;
    logic              in_range;
    logic              wr_en;
    logic              rd_hs;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              rd_valid_q, rd_valid_d;
    logic              rd_err_q, rd_err_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    // ------------------------------------------------------------------
    // Control FSM: CLEAR walks every word once, then IDLE serves requests.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= (CLEAR_EN != 0) ? ST_CLEAR : ST_IDLE;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        fill_we   = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                fill_we = 1'b1;
                if (clr_ptr_q == LAST_ADDR) begin
                    state_d   = ST_IDLE;
                    clr_ptr_d = '0;
                end else begin
                    clr_ptr_d = clr_ptr_q + AW'(1);
                end
            end
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Handshake: a request transfers on a rising edge where req_valid and
    // req_ready are both high; the requester holds it stable until then.
    // Responses are a single-cycle rsp_valid pulse with no backpressure.
    assign req_ready = (state_q == ST_IDLE) & ~rst;
    assign init_done = (state_q == ST_IDLE) & ~rst;

    assign hs       = req_valid & req_ready;
    assign in_range = {1'b0, req_addr} < DEPTH_W;
    assign wr_en    = hs & req_we & in_range;
    assign rd_hs    = hs & ~req_we;

    // Storage has no reset; only the fill sequence initialises it.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            mem_q[clr_ptr_q] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (req_be[i]) begin
                    mem_q[req_addr][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read stage: data and error captured only on a read handshake so the
    // response bus holds its last value between reads.
    // ------------------------------------------------------------------
    always_comb begin
        rd_valid_d = rd_hs;
        rd_err_d   = rd_err_q;
        rd_data_d  = rd_data_q;
        if (rd_hs) begin
            rd_err_d  = ~in_range;
            rd_data_d = in_range ? mem_q[req_addr] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_valid_d;
            rd_err_q   <= rd_err_d;
            rd_data_q  <= rd_data_d;
        end
    end

`ifdef SRAM_OUTREG_EN
    logic              out_valid_q, out_valid_d;
    logic              out_err_q, out_err_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;

    always_comb begin
        out_valid_d = rd_valid_q;
        out_err_d   = out_err_q;
        out_data_d  = out_data_q;
        if (rd_valid_q) begin
            out_err_d  = rd_err_q;
            out_data_d = rd_data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_err_q   <= out_err_d;
            out_data_q  <= out_data_d;
        end
    end

    assign rsp_valid = out_valid_q;
    assign rsp_err   = out_err_q;
    assign rsp_rdata = out_data_q;
`else
    assign rsp_valid = rd_valid_q;
    assign rsp_err   = rd_err_q;
    assign rsp_rdata = rd_data_q;
`endif

endmodule

// File: tb/tb_sram_sp_bytemask_ctl.sv
// Bench for sram_sp_bytemask_ctl: a 32x100 filled instance and a 64x16 unfilled instance,
// each driven cycle by cycle and checked against a word-array reference model.

module tb_sram_sp_bytemask_ctl;

`ifdef SRAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int A_DEPTH = 100;
    localparam int C_DEPTH = 16;

    // ---------------- clock ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- DUT A: 32 bit x 100 words, zero-fill ----------------
    logic        a_rst = 1'b1, a_valid = 1'b0, a_we = 1'b0;
    logic [3:0]  a_be = '0;
    logic [6:0]  a_addr = '0;
    logic [31:0] a_wdata = '0;
    logic        a_ready, a_rsp_valid, a_err, a_init;
    logic [31:0] a_rdata;

    sram_sp_bytemask_ctl #(.DATA_W(32), .DEPTH(A_DEPTH), .CLEAR_EN(1)) dut_a (
        .clk(clk), .rst(a_rst), .req_valid(a_valid), .req_ready(a_ready),
        .req_we(a_we), .req_be(a_be), .req_addr(a_addr), .req_wdata(a_wdata),
        .rsp_valid(a_rsp_valid), .rsp_rdata(a_rdata), .rsp_err(a_err), .init_done(a_init)
    );

    // ---------------- DUT C: 64 bit x 16 words, no fill ----------------
    logic        c_rst = 1'b1, c_valid = 1'b0, c_we = 1'b0;
    logic [7:0]  c_be = '0;
    logic [3:0]  c_addr = '0;
    logic [63:0] c_wdata = '0;
    logic        c_ready, c_rsp_valid, c_err, c_init;
    logic [63:0] c_rdata;

    sram_sp_bytemask_ctl #(.DATA_W(64), .DEPTH(C_DEPTH), .CLEAR_EN(0)) dut_c (
        .clk(clk), .rst(c_rst), .req_valid(c_valid), .req_ready(c_ready),
        .req_we(c_we), .req_be(c_be), .req_addr(c_addr), .req_wdata(c_wdata),
        .rsp_valid(c_rsp_valid), .rsp_rdata(c_rdata), .rsp_err(c_err), .init_done(c_init)
    );

    // ---------------- scoreboard state ----------------
    logic [31:0] a_ref [A_DEPTH];
    logic [31:0] exp_q [$];
    logic        a_err_q [$];
    int          a_due_q [$];
    int          a_edge = 0;
    int          a_fill_left = 0;
    logic [31:0] a_last = '0;

    logic [63:0] c_ref [C_DEPTH];
    logic [7:0]  c_known [C_DEPTH];
    logic [63:0] c_exp_q [$];
    logic [63:0] c_mask_q [$];
    int          c_due_q [$];
    int          c_edge = 0;
    logic [63:0] c_last = '0;
    logic [63:0] c_last_mask = '1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] lane_mask(input logic [7:0] k);
        logic [63:0] m;
        for (int i = 0; i < 8; i++) m[8*i +: 8] = {8{k[i]}};
        return m;
    endfunction

    // ---------------- driver + model, DUT A ----------------
    task automatic a_cycle(input logic v, input logic we, input logic [3:0] be,
                           input logic [6:0] addr, input logic [31:0] wd, input logic rs);
        logic        exp_rdy, hs, e;
        logic [31:0] rd;
        a_rst = rs; a_valid = v; a_we = we; a_be = be; a_addr = addr; a_wdata = wd;
        #1;
        exp_rdy = !rs && (a_fill_left == 0);
        chk("a_req_ready", 64'(a_ready), 64'(exp_rdy));
        chk("a_init_done", 64'(a_init), 64'(exp_rdy));
        hs = v && exp_rdy;
        @(posedge clk);
        a_edge++;
        if (rs) begin
            exp_q.delete(); a_err_q.delete(); a_due_q.delete();
            a_last = '0;
            a_fill_left = A_DEPTH;
            foreach (a_ref[i]) a_ref[i] = '0;
        end else begin
            if (a_fill_left > 0) a_fill_left--;
            if (hs && we) begin
                if (int'(addr) < A_DEPTH)
                    for (int i = 0; i < 4; i++)
                        if (be[i]) a_ref[addr][8*i +: 8] = wd[8*i +: 8];
            end else if (hs) begin
                rd = '0;
                if (int'(addr) < A_DEPTH) rd = a_ref[addr];
                exp_q.push_back(rd);
                a_err_q.push_back(int'(addr) >= A_DEPTH);
                a_due_q.push_back(a_edge + LAT - 1);
            end
        end
        #1;
        if (a_due_q.size() > 0 && a_due_q[0] == a_edge) begin
            rd = exp_q.pop_front();
            e  = a_err_q.pop_front();
            void'(a_due_q.pop_front());
            chk("a_rsp_valid", 64'(a_rsp_valid), 64'(1'b1));
            chk("a_rsp_rdata", 64'(a_rdata), 64'(rd));
            chk("a_rsp_err", 64'(a_err), 64'(e));
            a_last = rd;
        end else begin
            chk("a_rsp_valid_idle", 64'(a_rsp_valid), 64'(1'b0));
            chk("a_rsp_rdata_hold", 64'(a_rdata), 64'(a_last));
        end
    endtask

    task automatic a_idle(input int n);
        repeat (n) a_cycle(1'b0, 1'b0, 4'h0, 7'd0, 32'h0, 1'b0);
    endtask

    // ---------------- driver + model, DUT C ----------------
    task automatic c_cycle(input logic v, input logic we, input logic [7:0] be,
                           input logic [3:0] addr, input logic [63:0] wd, input logic rs);
        logic        hs;
        logic [63:0] rd, m;
        c_rst = rs; c_valid = v; c_we = we; c_be = be; c_addr = addr; c_wdata = wd;
        #1;
        chk("c_req_ready", 64'(c_ready), 64'(!rs));
        chk("c_init_done", 64'(c_init), 64'(!rs));
        hs = v && !rs;
        @(posedge clk);
        c_edge++;
        if (rs) begin
            c_exp_q.delete(); c_mask_q.delete(); c_due_q.delete();
            c_last = '0;
            c_last_mask = '1;
            foreach (c_known[i]) c_known[i] = '0;
        end else if (hs && we) begin
            for (int i = 0; i < 8; i++)
                if (be[i]) begin
                    c_ref[addr][8*i +: 8] = wd[8*i +: 8];
                    c_known[addr][i] = 1'b1;
                end
        end else if (hs) begin
            c_exp_q.push_back(c_ref[addr]);
            c_mask_q.push_back(lane_mask(c_known[addr]));
            c_due_q.push_back(c_edge + LAT - 1);
        end
        #1;
        if (c_due_q.size() > 0 && c_due_q[0] == c_edge) begin
            rd = c_exp_q.pop_front();
            m  = c_mask_q.pop_front();
            void'(c_due_q.pop_front());
            chk("c_rsp_valid", 64'(c_rsp_valid), 64'(1'b1));
            chk("c_rsp_rdata", c_rdata & m, rd & m);
            chk("c_rsp_err", 64'(c_err), 64'(1'b0));
            c_last = rd;
            c_last_mask = m;
        end else begin
            chk("c_rsp_valid_idle", 64'(c_rsp_valid), 64'(1'b0));
            chk("c_rsp_rdata_hold", c_rdata & c_last_mask, c_last & c_last_mask);
        end
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [6:0] ra;

        // power-up reset, then requests offered during fill must be ignored
        a_cycle(1'b0, 1'b0, 4'h0, 7'd0, 32'h0, 1'b1);
        for (int i = 0; i < 60; i++)
            a_cycle(1'($urandom_range(1, 0)), 1'b1, 4'hF, 7'd5, $urandom(), 1'b0);

        // reset mid-fill: fill restarts and takes DEPTH cycles again
        a_cycle(1'b0, 1'b0, 4'h0, 7'd0, 32'h0, 1'b1);
        a_idle(A_DEPTH);

        // every word reads back zero, back-to-back
        for (int i = 0; i < A_DEPTH; i++)
            a_cycle(1'b1, 1'b0, 4'h0, 7'(i), 32'h0, 1'b0);
        a_idle(LAT + 1);

        // byte-lane merge
        a_cycle(1'b1, 1'b1, 4'hF, 7'd5, 32'h11223344, 1'b0);
        a_cycle(1'b1, 1'b1, 4'b0101, 7'd5, 32'hAABBCCDD, 1'b0);
        a_cycle(1'b1, 1'b0, 4'h0, 7'd5, 32'h0, 1'b0);
        a_idle(3);

        // out-of-range write/read, neighbour untouched, write-then-read
        a_cycle(1'b1, 1'b1, 4'hF, 7'd100, 32'hDEADBEEF, 1'b0);
        a_cycle(1'b1, 1'b0, 4'h0, 7'd100, 32'h0, 1'b0);
        a_cycle(1'b1, 1'b0, 4'h0, 7'd99, 32'h0, 1'b0);
        a_cycle(1'b1, 1'b1, 4'hF, 7'd99, 32'h12345678, 1'b0);
        a_cycle(1'b1, 1'b0, 4'h0, 7'd99, 32'h0, 1'b0);
        a_cycle(1'b1, 1'b1, 4'h0, 7'd99, 32'hFFFFFFFF, 1'b0);
        a_cycle(1'b1, 1'b0, 4'h0, 7'd99, 32'h0, 1'b0);
        a_idle(3);

        // consecutive reads, then the bus must hold
        a_cycle(1'b1, 1'b0, 4'h0, 7'd0, 32'h0, 1'b0);
        a_cycle(1'b1, 1'b0, 4'h0, 7'd1, 32'h0, 1'b0);
        a_cycle(1'b1, 1'b0, 4'h0, 7'd2, 32'h0, 1'b0);
        a_idle(4);

        // random traffic, mostly low addresses with some out-of-range
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(9, 0))
                0:       ra = 7'($urandom_range(127, 100));
                1:       ra = 7'($urandom_range(99, 96));
                default: ra = 7'($urandom_range(15, 0));
            endcase
            a_cycle(1'($urandom_range(3, 0) != 0), 1'($urandom_range(1, 0)),
                    4'($urandom_range(15, 0)), ra, $urandom(), 1'b0);
        end
        a_idle(LAT + 1);

        // reset with a read in flight, then memory is zero again
        a_cycle(1'b1, 1'b1, 4'hF, 7'd7, 32'h5A5A5A5A, 1'b0);
        a_cycle(1'b1, 1'b0, 4'h0, 7'd7, 32'h0, 1'b0);
        a_cycle(1'b0, 1'b0, 4'h0, 7'd0, 32'h0, 1'b1);
        a_idle(A_DEPTH);
        a_cycle(1'b1, 1'b0, 4'h0, 7'd7, 32'h0, 1'b0);
        a_idle(3);

        // wide instance without fill: ready right after reset
        c_cycle(1'b0, 1'b0, 8'h0, 4'd0, 64'h0, 1'b1);
        c_cycle(1'b1, 1'b1, 8'h80, 4'd3, 64'hFFFFFFFF_FFFFFFFF, 1'b0);
        c_cycle(1'b1, 1'b0, 8'h0, 4'd3, 64'h0, 1'b0);
        c_cycle(1'b1, 1'b1, 8'hFF, 4'd4, 64'h01234567_89ABCDEF, 1'b0);
        c_cycle(1'b1, 1'b1, 8'h0F, 4'd4, 64'h11111111_CAFEF00D, 1'b0);
        c_cycle(1'b1, 1'b0, 8'h0, 4'd4, 64'h0, 1'b0);
        repeat (3) c_cycle(1'b0, 1'b0, 8'h0, 4'd0, 64'h0, 1'b0);
        for (int i = 0; i < 150; i++)
            c_cycle(1'($urandom_range(3, 0) != 0), 1'($urandom_range(1, 0)),
                    8'($urandom_range(255, 0)), 4'($urandom_range(15, 0)),
                    {$urandom(), $urandom()}, 1'b0);
        repeat (LAT + 1) c_cycle(1'b0, 1'b0, 8'h0, 4'd0, 64'h0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
